rxacl_buf_drain_ctrl: RTL and testbench

- Read-side sequencer for the RX ACL payload ping-pong buffer (two 256x32 single-port SRAM banks).
- Tracks how many banks hold committed good packets, each with its payload byte length.
- Drains the oldest bank word by word to the host interface over a valid/ready handshake.
- Drives the bank read port: bsm_addr, bsm_cs, and a bsm_valid_p pulse that retires the bank.
- Reports buffer-full so the link controller can signal FLOW stop / NAK.

---
 rtl/rxacl_buf_drain_ctrl_pkg.sv | 26 ++
 rtl/rxacl_buf_drain_ctrl_len_fifo2.sv | 51 +++++
 rtl/rxacl_buf_drain_ctrl.sv | 135 +++++++++++++
 tb/tb_rxacl_buf_drain_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rxacl_buf_drain_ctrl_pkg.sv
// Shared widths, FSM encoding and length helper
// for the RX ACL ping-pong buffer drain path.
package rxacl_buf_drain_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int LEN_W  = 10;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_PRES,
    ST_ADV
  } state_t;

  // Index of the final 32-bit word holding a payload of len bytes.
  function automatic logic [ADDR_W-1:0] last_idx(
    input logic [LEN_W-1:0] len
  );
    logic [ADDR_W-1:0] w;
    w = len[LEN_W-1:2];
    return (len[1:0] == 2'b00) ? w - ADDR_W'(1) : w;
  endfunction

endpackage

// File: rtl/rxacl_buf_drain_ctrl_len_fifo2.sv
// Two-entry length FIFO, one slot per SRAM bank.
// A same-cycle push and pop keeps the count unchanged.
import rxacl_buf_drain_ctrl_pkg::*;

module rxacl_len_fifo2 (
  input  logic             clk_6M,
  input  logic             rstz,
  input  logic             push,
  input  logic             pop,
  input  logic [LEN_W-1:0] din,
  output logic [LEN_W-1:0] head,
  output logic [1:0]       count
);

  logic [LEN_W-1:0] slot0;
  logic [LEN_W-1:0] slot1;

  assign head = slot0;

  // Slot 0 always holds the oldest pending length.
  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= '0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (count == 2'd2) begin
            slot0 <= slot1;
            slot1 <= din;
          end else begin
            slot0 <= din;
          end
        end
        2'b01: begin
          slot0 <= slot1;
          slot1 <= '0;
          count <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) slot0 <= din;
          else               slot1 <= din;
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rxacl_buf_drain_ctrl.sv
// Read-side sequencer: drains the oldest committed bank
// word by word to the host and retires the bank.
import rxacl_buf_drain_ctrl_pkg::*;

module rxacl_buf_drain_ctrl (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              rx_commit_p,
  input  logic [LEN_W-1:0]  rx_pylenByte,
  input  logic              flush_p,
  input  logic              host_rdy,
  input  logic [DATA_W-1:0] bsm_dout,
  output logic [ADDR_W-1:0] bsm_addr,
  output logic              bsm_cs,
  output logic              bsm_valid_p,
  output logic [DATA_W-1:0] host_data,
  output logic              host_valid,
  output logic              host_sop,
  output logic              host_eop,
  output logic [LEN_W-1:0]  host_len,
  output logic              buf_full,
  output logic              ovf_p
);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_n;
  logic              sop_flag;
  logic              sop_n;
  logic              pop;
  logic              push;
  logic              cap;
  logic              commit_ok;
  logic              flush_eff;
  logic [1:0]        cnt;
  logic [LEN_W-1:0]  head;
  logic [ADDR_W-1:0] last;

  assign commit_ok = rx_commit_p && (rx_pylenByte != '0);
  assign push      = commit_ok && ((cnt != 2'd2) || pop);
  assign flush_eff = flush_p && (cnt != 2'd0);
  assign last      = last_idx(head);

  rxacl_len_fifo2 u_len_fifo (
    .clk_6M (clk_6M),
    .rstz   (rstz),
    .push   (push),
    .pop    (pop),
    .din    (rx_pylenByte),
    .head   (head),
    .count  (cnt)
  );

  // Next state, word pointer and read-port strobes.
  always_comb begin
    state_n     = state;
    addr_n      = addr;
    sop_n       = sop_flag;
    bsm_cs      = 1'b0;
    bsm_valid_p = 1'b0;
    host_valid  = 1'b0;
    pop         = 1'b0;
    cap         = 1'b0;
    if (flush_eff) begin
      state_n = ST_ADV;
      addr_n  = last;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cnt != 2'd0) begin
            addr_n  = '0;
            sop_n   = 1'b1;
            state_n = ST_RD;
          end
        end
        ST_RD: begin
          bsm_cs  = 1'b1;
          state_n = ST_CAP;
        end
        ST_CAP: begin
          cap     = 1'b1;
          state_n = ST_PRES;
        end
        ST_PRES: begin
          host_valid = 1'b1;
          if (host_rdy) state_n = ST_ADV;
        end
        ST_ADV: begin
          bsm_valid_p = 1'b1;
          sop_n       = 1'b0;
          if (addr == last) begin
            pop     = 1'b1;
            state_n = ST_IDLE;
          end else begin
            addr_n  = addr + ADDR_W'(1);
            state_n = ST_RD;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // FSM registers.
  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      state    <= ST_IDLE;
      addr     <= '0;
      sop_flag <= 1'b0;
    end else begin
      state    <= state_n;
      addr     <= addr_n;
      sop_flag <= sop_n;
    end
  end

  // Capture SRAM data and flag dropped commits.
  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      host_data <= '0;
      ovf_p     <= 1'b0;
    end else begin
      if (cap) host_data <= bsm_dout;
      ovf_p <= commit_ok && (cnt == 2'd2) && !pop;
    end
  end

  assign bsm_addr = addr;
  assign host_sop = host_valid && sop_flag;
  assign host_eop = host_valid && (addr == last);
  assign host_len = host_valid ? head : '0;
  assign buf_full = (cnt == 2'd2);

endmodule

// File: tb/tb_rxacl_buf_drain_ctrl.sv
// Self-checking bench for rxacl_buf_drain_ctrl with an
// SRAM model, table-driven packets and corner sequences.
import rxacl_buf_drain_ctrl_pkg::*;

module tb_rxacl_buf_drain_ctrl;

  logic              clk_6M = 1'b0;
  logic              rstz = 1'b0;
  logic              rx_commit_p = 1'b0;
  logic [LEN_W-1:0]  rx_pylenByte = '0;
  logic              flush_p = 1'b0;
  logic              host_rdy = 1'b0;
  logic [DATA_W-1:0] bsm_dout = '0;
  logic [ADDR_W-1:0] bsm_addr;
  logic              bsm_cs;
  logic              bsm_valid_p;
  logic [DATA_W-1:0] host_data;
  logic              host_valid;
  logic              host_sop;
  logic              host_eop;
  logic [LEN_W-1:0]  host_len;
  logic              buf_full;
  logic              ovf_p;

  rxacl_buf_drain_ctrl dut (
    .clk_6M       (clk_6M),
    .rstz         (rstz),
    .rx_commit_p  (rx_commit_p),
    .rx_pylenByte (rx_pylenByte),
    .flush_p      (flush_p),
    .host_rdy     (host_rdy),
    .bsm_dout     (bsm_dout),
    .bsm_addr     (bsm_addr),
    .bsm_cs       (bsm_cs),
    .bsm_valid_p  (bsm_valid_p),
    .host_data    (host_data),
    .host_valid   (host_valid),
    .host_sop     (host_sop),
    .host_eop     (host_eop),
    .host_len     (host_len),
    .buf_full     (buf_full),
    .ovf_p        (ovf_p)
  );

  always #5 clk_6M = ~clk_6M;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [9:0]  len;
  } word_t;

  typedef struct {
    logic [9:0] len;
    int         last;
  } vec_t;

  word_t      exp_w_q[$];
  logic [7:0] exp_ret_q[$];
  logic [7:0] pkt_last_q[$];

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_ret = 0;
  int n_cs = 0;
  int n_ovf = 0;
  logic [7:0] last_ret = '0;
  logic [7:0] rd_pkt = '0;
  logic [7:0] wr_pkt = '0;
  logic       mon_en = 1'b0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // SRAM model: registered read, tag bumps on bank retire.
  always @(posedge clk_6M) begin
    if (bsm_cs)
      bsm_dout <= {rd_pkt, 8'h5A, 8'h00, bsm_addr};
    if (!rstz) begin
      rd_pkt <= '0;
    end else if (bsm_valid_p && pkt_last_q.size() > 0 &&
                 bsm_addr == pkt_last_q[0]) begin
      void'(pkt_last_q.pop_front());
      rd_pkt <= rd_pkt + 8'd1;
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk_6M) begin : mon
    word_t      e;
    logic [7:0] r;
    if (mon_en) begin
      if (host_valid && host_rdy && !flush_p) begin
        n_acc++;
        if (exp_w_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL word: got %0h, none expected",
                   host_data);
        end else begin
          e = exp_w_q.pop_front();
          chk("word",
              {20'h0, host_data, host_sop, host_eop, host_len},
              {20'h0, e});
        end
      end
      if (bsm_valid_p) begin
        n_ret++;
        last_ret = bsm_addr;
        if (exp_ret_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL ret: got addr %0d, none expected",
                   bsm_addr);
        end else begin
          r = exp_ret_q.pop_front();
          chk("ret_addr", 64'(bsm_addr), 64'(r));
        end
      end
      if (bsm_cs) begin
        n_cs++;
        chk("cs_excl", 64'({bsm_valid_p, host_valid}), 64'(0));
      end
      if (ovf_p) n_ovf++;
    end
  end

  task automatic tick();
    @(posedge clk_6M);
    #2;
  endtask

  task automatic commit(input logic [9:0] len);
    rx_pylenByte = len;
    rx_commit_p  = 1'b1;
    tick();
    rx_commit_p  = 1'b0;
    rx_pylenByte = '0;
  endtask

  task automatic push_pkt(input logic [9:0] len,
                          input int last);
    word_t e;
    for (int i = 0; i <= last; i++) begin
      e.data = {wr_pkt, 8'h5A, 8'h00, 8'(i)};
      e.sop  = (i == 0);
      e.eop  = (i == last);
      e.len  = len;
      exp_w_q.push_back(e);
      exp_ret_q.push_back(8'(i));
    end
    pkt_last_q.push_back(8'(last));
    wr_pkt++;
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_w_q.size() == 0 && exp_ret_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk("drain", 64'(done), 64'(1));
    repeat (3) tick();
  endtask

  task automatic wait_valid(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (host_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_valid", 64'(ok), 64'(1));
  endtask

  task automatic chk_outs_zero(input string name);
    chk(name, 64'({bsm_addr, bsm_cs, bsm_valid_p,
                   host_valid, host_sop, host_eop,
                   host_len, buf_full, ovf_p, host_data}),
        64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    vec_t  vt[9];
    word_t e0;
    int    n0;
    int    c0;
    int    r0;
    int    o0;
    bit    ok;

    vt[0] = '{10'd10,   2};
    vt[1] = '{10'd1,    0};
    vt[2] = '{10'd4,    0};
    vt[3] = '{10'd5,    1};
    vt[4] = '{10'd8,    1};
    vt[5] = '{10'd13,   3};
    vt[6] = '{10'd16,   3};
    vt[7] = '{10'd1023, 255};
    vt[8] = '{10'd1020, 254};

    rstz = 1'b0;
    repeat (3) tick();
    chk_outs_zero("reset_outs");
    rstz   = 1'b1;
    mon_en = 1'b1;
    tick();

    // single packets, host always ready
    host_rdy = 1'b1;
    foreach (vt[k]) begin
      n0 = n_acc;
      commit(vt[k].len);
      push_pkt(vt[k].len, vt[k].last);
      wait_drain(1500);
      chk("words", 64'(n_acc - n0), 64'(vt[k].last + 1));
      chk("last_idx", 64'(last_ret), 64'(vt[k].last));
      chk("idle_after", 64'({host_valid, buf_full}), 64'(0));
    end

    // back-to-back commits fill both banks
    n0 = n_acc;
    commit(10'd8);
    commit(10'd1023);
    chk("buf_full_2", 64'(buf_full), 64'(1));
    push_pkt(10'd8, 1);
    push_pkt(10'd1023, 255);
    wait_drain(1500);
    chk("b2b_words", 64'(n_acc - n0), 64'(258));
    chk("b2b_last", 64'(last_ret), 64'(255));
    chk("b2b_empty", 64'(buf_full), 64'(0));

    // third commit with no pop is dropped
    host_rdy = 1'b0;
    o0 = n_ovf;
    n0 = n_acc;
    commit(10'd4);
    commit(10'd4);
    commit(10'd4);
    chk("ovf_pulse", 64'(ovf_p), 64'(1));
    tick();
    chk("ovf_clear", 64'(ovf_p), 64'(0));
    chk("ovf_full", 64'(buf_full), 64'(1));
    push_pkt(10'd4, 0);
    push_pkt(10'd4, 0);
    host_rdy = 1'b1;
    wait_drain(100);
    repeat (10) tick();
    chk("ovf_count", 64'(n_ovf - o0), 64'(1));
    chk("ovf_pkts", 64'(n_acc - n0), 64'(2));
    chk("ovf_empty", 64'(buf_full), 64'(0));

    // commit at full in the same cycle as the pop
    host_rdy = 1'b0;
    o0 = n_ovf;
    commit(10'd4);
    commit(10'd4);
    push_pkt(10'd4, 0);
    push_pkt(10'd4, 0);
    wait_valid(20);
    host_rdy = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bsm_valid_p) begin
        ok = 1'b1;
        break;
      end
    end
    chk("adv_seen", 64'(ok), 64'(1));
    commit(10'd4);
    push_pkt(10'd4, 0);
    chk("pop_push_ovf", 64'(ovf_p), 64'(0));
    chk("pop_push_full", 64'(buf_full), 64'(1));
    wait_drain(100);
    chk("pop_push_novf", 64'(n_ovf - o0), 64'(0));

    // host stall holds the presented word
    host_rdy = 1'b0;
    e0 = '{data: {wr_pkt, 8'h5A, 16'h0000}, sop: 1'b1,
           eop: 1'b0, len: 10'd12};
    commit(10'd12);
    push_pkt(10'd12, 2);
    wait_valid(20);
    c0 = n_cs;
    repeat (20) begin
      tick();
      chk("stall_hold",
          {19'h0, host_valid, host_data, host_sop,
           host_eop, host_len},
          {19'h0, 1'b1, e0});
    end
    chk("stall_cs", 64'(n_cs - c0), 64'(0));
    host_rdy = 1'b1;
    wait_drain(100);

    // accept one word, then flush with rdy high
    host_rdy = 1'b0;
    e0 = '{data: {wr_pkt, 8'h5A, 16'h0000}, sop: 1'b1,
           eop: 1'b0, len: 10'd20};
    commit(10'd20);
    exp_w_q.push_back(e0);
    exp_ret_q.push_back(8'd0);
    exp_ret_q.push_back(8'd4);
    pkt_last_q.push_back(8'd4);
    wr_pkt++;
    wait_valid(20);
    host_rdy = 1'b1;
    tick();
    host_rdy = 1'b0;
    tick();
    wait_valid(20);
    r0 = n_ret;
    n0 = n_acc;
    host_rdy = 1'b1;
    flush_p  = 1'b1;
    tick();
    flush_p  = 1'b0;
    host_rdy = 1'b0;
    wait_drain(20);
    chk("flush_rets", 64'(n_ret - r0), 64'(1));
    chk("flush_addr", 64'(last_ret), 64'(4));
    chk("flush_noacc", 64'(n_acc - n0), 64'(0));
    chk("flush_empty", 64'(buf_full), 64'(0));

    // zero-length commit and empty flush are ignored
    c0 = n_cs;
    r0 = n_ret;
    commit(10'd0);
    repeat (10) tick();
    flush_p = 1'b1;
    tick();
    flush_p = 1'b0;
    repeat (5) tick();
    chk("zero_len_cs", 64'(n_cs - c0), 64'(0));
    chk("empty_flush", 64'(n_ret - r0), 64'(0));
    chk("zero_len_outs",
        64'({host_valid, buf_full, ovf_p}), 64'(0));
    host_rdy = 1'b1;
    n0 = n_acc;
    commit(10'd6);
    push_pkt(10'd6, 1);
    wait_drain(50);
    chk("post_words", 64'(n_acc - n0), 64'(2));

    // reset mid-packet drops pending lengths
    host_rdy = 1'b0;
    commit(10'd40);
    commit(10'd8);
    wait_valid(20);
    rstz = 1'b0;
    tick();
    chk_outs_zero("midrst_outs");
    rstz = 1'b1;
    exp_w_q.delete();
    exp_ret_q.delete();
    pkt_last_q.delete();
    wr_pkt   = '0;
    host_rdy = 1'b1;
    repeat (10) tick();
    chk("midrst_idle", 64'({host_valid, buf_full}), 64'(0));
    n0 = n_acc;
    commit(10'd3);
    push_pkt(10'd3, 0);
    wait_drain(50);
    chk("midrst_words", 64'(n_acc - n0), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
